// File: rtl/switch_channel_driver_if.sv
// Interface bundle between the channel counter, the switch driver and the gate pins.
// The slave modport is the driver's view. The master modport is the upstream/stimulus view.
interface switch_channel_driver_if #(
  parameter int N_CH = 10
);
  logic            en;
  logic [3:0]      idx;
  logic            idx_valid;
  logic [N_CH-1:0] sw_out;
  logic [3:0]      active_idx;
  logic            busy;
  logic            settled;
  logic            err;

  modport master (
    output en, idx, idx_valid,
    input  sw_out, active_idx, busy, settled, err
  );

  modport slave (
    input  en, idx, idx_valid,
    output sw_out, active_idx, busy, settled, err
  );
endinterface

// File: rtl/switch_channel_driver.sv
// Break-before-make photonic switch gate driver.
// Turns channel index strobes into a one-hot gate drive, with a dead time and a settle interval.
module switch_channel_driver #(
  parameter int N_CH       = 10,
  parameter int DEAD_CYC   = 2,
  parameter int SETTLE_CYC = 5
) (
  input logic                    clk,
  input logic                    rst,
  switch_channel_driver_if.slave bus
);

  localparam int CNT_MAX = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] DEAD_LOAD   = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BREAK  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [N_CH-1:0] sw_out_q, sw_out_d;
  logic [3:0]      active_idx_q, active_idx_d;
  logic            busy_q, busy_d;
  logic            settled_q, settled_d;
  logic            err_q, err_d;
  logic            pend_vld_q, pend_vld_d;
  logic [3:0]      pend_idx_q, pend_idx_d;
  logic [3:0]      tgt_idx_q, tgt_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            req_ok_s;
  logic            req_bad_s;
  logic            hold_req_vld_s;
  logic [3:0]      hold_req_idx_s;

  function automatic logic [N_CH-1:0] onehot(input logic [3:0] i);
    logic [N_CH-1:0] oh;
    oh = '0;
    for (int j = 0; j < N_CH; j++) begin
      oh[j] = (i == 4'(j));
    end
    return oh;
  endfunction

  assign req_ok_s  = bus.en & bus.idx_valid & ({1'b0, bus.idx} <  5'(N_CH));
  assign req_bad_s = bus.en & bus.idx_valid & ({1'b0, bus.idx} >= 5'(N_CH));

  // A live strobe in HOLD takes priority over a request parked while switching.
  always_comb begin
    hold_req_vld_s = 1'b0;
    hold_req_idx_s = 4'd0;
    if (req_ok_s) begin
      hold_req_vld_s = 1'b1;
      hold_req_idx_s = bus.idx;
    end else if (pend_vld_q) begin
      hold_req_vld_s = 1'b1;
      hold_req_idx_s = pend_idx_q;
    end else begin
      hold_req_vld_s = 1'b0;
      hold_req_idx_s = 4'd0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    sw_out_d     = sw_out_q;
    active_idx_d = active_idx_q;
    busy_d       = busy_q;
    settled_d    = 1'b0;
    err_d        = err_q | req_bad_s;
    pend_vld_d   = pend_vld_q;
    pend_idx_d   = pend_idx_q;
    tgt_idx_d    = tgt_idx_q;
    cnt_d        = cnt_q;

    if (!bus.en) begin
      state_d    = ST_IDLE;
      sw_out_d   = '0;
      busy_d     = 1'b0;
      pend_vld_d = 1'b0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_ok_s) begin
            state_d      = ST_SETTLE;
            sw_out_d     = onehot(bus.idx);
            active_idx_d = bus.idx;
            busy_d       = 1'b1;
            cnt_d        = SETTLE_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          pend_vld_d = 1'b0;
          if (hold_req_vld_s && (hold_req_idx_s != active_idx_q)) begin
            state_d   = ST_BREAK;
            sw_out_d  = '0;
            busy_d    = 1'b1;
            tgt_idx_d = hold_req_idx_s;
            cnt_d     = DEAD_LOAD;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_BREAK, ST_SETTLE: begin
          if (req_ok_s) begin
            pend_vld_d = 1'b1;
            pend_idx_d = bus.idx;
          end else begin
            pend_vld_d = pend_vld_q;
          end
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (state_q == ST_BREAK) begin
            state_d      = ST_SETTLE;
            sw_out_d     = onehot(tgt_idx_q);
            active_idx_d = tgt_idx_q;
            cnt_d        = SETTLE_LOAD;
          end else begin
            state_d   = ST_HOLD;
            busy_d    = 1'b0;
            settled_d = 1'b1;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          sw_out_d   = '0;
          busy_d     = 1'b0;
          pend_vld_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sw_out_q     <= '0;
      active_idx_q <= 4'd0;
      busy_q       <= 1'b0;
      settled_q    <= 1'b0;
      err_q        <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_idx_q   <= 4'd0;
      tgt_idx_q    <= 4'd0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      sw_out_q     <= sw_out_d;
      active_idx_q <= active_idx_d;
      busy_q       <= busy_d;
      settled_q    <= settled_d;
      err_q        <= err_d;
      pend_vld_q   <= pend_vld_d;
      pend_idx_q   <= pend_idx_d;
      tgt_idx_q    <= tgt_idx_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.sw_out     = sw_out_q;
  assign bus.active_idx = active_idx_q;
  assign bus.busy       = busy_q;
  assign bus.settled    = settled_q;
  assign bus.err        = err_q;

endmodule
